// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with fixed wait states and a one-cycle Ready pulse
// Flags misaligned, out-of-range and read+write requests; counts committed writes.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Err,
  output logic [15:0] WriteCount
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] wcount_q, wcount_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        cur_wr, cur_rd, cur_err, finish, mem_we;
  logic [31:0] cur_adr, cur_wdata, off;
  logic [AW-1:0] idx;
  logic        unused_off;

  // With zero wait states the request resolves on its acceptance edge, so the
  // live inputs stand in for the not-yet-latched request.
  always_comb begin
    cur_wr    = (state_q == S_IDLE) ? MemWrite  : wr_q;
    cur_rd    = (state_q == S_IDLE) ? MemRead   : rd_q;
    cur_adr   = (state_q == S_IDLE) ? DataAdr   : adr_q;
    cur_wdata = (state_q == S_IDLE) ? WriteData : wdata_q;
    off       = cur_adr - BASE_ADDR;
    idx       = off[AW+1:2];
    cur_err   = (cur_adr[1:0] != 2'b00) ||
                ({1'b0, cur_adr} < {1'b0, BASE_ADDR}) ||
                ({1'b0, cur_adr} >= LIMIT) ||
                (cur_wr && cur_rd);
  end

  assign unused_off = ^{off[31:AW+2], off[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    wcount_d = wcount_q;
    finish   = 1'b0;
    mem_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MemWrite || MemRead) begin
          wr_d    = MemWrite;
          rd_d    = MemRead;
          adr_d   = DataAdr;
          wdata_d = WriteData;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            finish  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          finish  = 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // All response side effects happen on the edge entering RESP.
    if (finish) begin
      ready_d = 1'b1;
      err_d   = cur_err;
      if (cur_err) begin
        rdata_d = 32'h0;
      end else if (cur_wr) begin
        rdata_d = 32'h0;
        mem_we  = 1'b1;
        if (wcount_q != 16'hFFFF) wcount_d = wcount_q + 16'd1;
      end else begin
        rdata_d = mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      adr_q    <= 32'h0;
      wdata_q  <= 32'h0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      wcount_q <= 16'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      wcount_q <= wcount_d;
    end
  end

  // RAM is not cleared by reset; an edge with reset low drops the write.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[idx] <= cur_wdata;
  end

  assign ReadData   = rdata_q;
  assign Ready      = ready_q;
  assign Err        = err_q;
  assign WriteCount = wcount_q;

endmodule
